// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master / single-slave bus arbiter. Port 0 is the CPU, port 1 the
// DMA/loader. Read and write transactions are serialised one at a time and
// ties are broken round-robin. Every slave-side strobe and every master-side
// response is driven straight from a flop. Each read is owned until the slave
// answers or a timeout expires, so a slave that never raises s_rd_valid cannot
// hang the bus. A timeout completes the read with zero data and raises a
// sticky error.
//
// Parameters
//   W        write data width
//   AW       address width
//   TIMEOUT  cycles to wait for s_rd_valid (1..255)
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   mN_ren / mN_wen          read / write request, held until completion
//   mN_addr/wdata/wmask      request address, write data, byte mask
//   mN_rd_valid / mN_wack    one-cycle read completion / write acceptance
//   m_rdata                  shared read data, meaningful with mN_rd_valid
//   s_ren / s_wen            one-cycle slave strobes
//   s_addr/s_wdata/s_wmask   slave address, write data, byte mask
//   s_rdata / s_rd_valid     slave read data and its valid
//   err / err_addr           sticky read-timeout flag, first timed-out address
//   err_clr                  clears err and err_addr
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int W       = 16,
    parameter int AW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_ren,
    input  logic          m0_wen,
    input  logic [AW-1:0] m0_addr,
    input  logic [W-1:0]  m0_wdata,
    input  logic [3:0]    m0_wmask,
    input  logic          m1_ren,
    input  logic          m1_wen,
    input  logic [AW-1:0] m1_addr,
    input  logic [W-1:0]  m1_wdata,
    input  logic [3:0]    m1_wmask,
    output logic          m0_rd_valid,
    output logic          m1_rd_valid,
    output logic          m0_wack,
    output logic          m1_wack,
    output logic [31:0]   m_rdata,
    output logic          s_ren,
    output logic          s_wen,
    output logic [AW-1:0] s_addr,
    output logic [W-1:0]  s_wdata,
    output logic [3:0]    s_wmask,
    input  logic [31:0]   s_rdata,
    input  logic          s_rd_valid,
    output logic          err,
    output logic [AW-1:0] err_addr,
    input  logic          err_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t          state_q,       state_d;
    logic            owner_q,       owner_d;
    logic            last_owner_q,  last_owner_d;
    logic [7:0]      cnt_q,         cnt_d;
    logic [AW-1:0]   s_addr_q,      s_addr_d;
    logic [W-1:0]    s_wdata_q,     s_wdata_d;
    logic [3:0]      s_wmask_q,     s_wmask_d;
    logic            s_ren_q,       s_ren_d;
    logic            s_wen_q,       s_wen_d;
    logic            m0_wack_q,     m0_wack_d;
    logic            m1_wack_q,     m1_wack_d;
    logic            m0_rd_valid_q, m0_rd_valid_d;
    logic            m1_rd_valid_q, m1_rd_valid_d;
    logic [31:0]     m_rdata_q,     m_rdata_d;
    logic            err_q,         err_d;
    logic [AW-1:0]   err_addr_q,    err_addr_d;

    logic            req0_s;
    logic            req1_s;
    logic            any_req_s;
    logic            gnt_s;
    logic            gnt_wen_s;
    logic [AW-1:0]   gnt_addr_s;
    logic [W-1:0]    gnt_wdata_s;
    logic [3:0]      gnt_wmask_s;
    logic            timeout_s;

    assign req0_s    = m0_ren | m0_wen;
    assign req1_s    = m1_ren | m1_wen;
    assign any_req_s = req0_s | req1_s;

    // Round-robin pick: on a tie the master that did not own the bus last wins.
    always_comb begin
        gnt_s = 1'b0;
        if (req0_s && req1_s) begin
            gnt_s = ~last_owner_q;
        end else if (req0_s) begin
            gnt_s = 1'b0;
        end else begin
            gnt_s = 1'b1;
        end
    end

    // Request fields of the master selected by the round-robin pick.
    always_comb begin
        gnt_wen_s   = 1'b0;
        gnt_addr_s  = '0;
        gnt_wdata_s = '0;
        gnt_wmask_s = 4'b0000;
        if (gnt_s) begin
            gnt_wen_s   = m1_wen;
            gnt_addr_s  = m1_addr;
            gnt_wdata_s = m1_wdata;
            gnt_wmask_s = m1_wmask;
        end else begin
            gnt_wen_s   = m0_wen;
            gnt_addr_s  = m0_addr;
            gnt_wdata_s = m0_wdata;
            gnt_wmask_s = m0_wmask;
        end
    end

    // Next-state and next-output logic; pulses default low, data holds.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        cnt_d         = cnt_q;
        s_addr_d      = s_addr_q;
        s_wdata_d     = s_wdata_q;
        s_wmask_d     = s_wmask_q;
        s_ren_d       = 1'b0;
        s_wen_d       = 1'b0;
        m0_wack_d     = 1'b0;
        m1_wack_d     = 1'b0;
        m0_rd_valid_d = 1'b0;
        m1_rd_valid_d = 1'b0;
        m_rdata_d     = m_rdata_q;
        err_d         = err_q;
        err_addr_d    = err_addr_q;
        timeout_s     = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    owner_d      = gnt_s;
                    last_owner_d = gnt_s;
                    s_addr_d     = gnt_addr_s;
                    s_wdata_d    = gnt_wdata_s;
                    s_wmask_d    = gnt_wmask_s;
                    // A write takes precedence over a simultaneous read.
                    if (gnt_wen_s) begin
                        state_d   = WR;
                        s_wen_d   = 1'b1;
                        m0_wack_d = ~gnt_s;
                        m1_wack_d = gnt_s;
                    end else begin
                        state_d = RD;
                        s_ren_d = 1'b1;
                        cnt_d   = 8'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD: begin
                // Data arriving in the timeout cycle still counts as a hit.
                if (s_rd_valid) begin
                    state_d       = RESP;
                    m_rdata_d     = s_rdata;
                    m0_rd_valid_d = ~owner_q;
                    m1_rd_valid_d = owner_q;
                end else if (cnt_q >= TIMEOUT_C) begin
                    state_d       = RESP;
                    m_rdata_d     = 32'h0000_0000;
                    m0_rd_valid_d = ~owner_q;
                    m1_rd_valid_d = owner_q;
                    timeout_s     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Clearing wins over a timeout landing in the same cycle; only the
        // first timeout since the last clear records its address.
        if (err_clr) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end else if (timeout_s) begin
            err_d = 1'b1;
            if (!err_q) begin
                err_addr_d = s_addr_q;
            end else begin
                err_addr_d = err_addr_q;
            end
        end else begin
            err_d      = err_q;
            err_addr_d = err_addr_q;
        end
    end

    // State and output registers; reset drops any in-flight read silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_owner_q  <= 1'b1;
            cnt_q         <= 8'd0;
            s_addr_q      <= '0;
            s_wdata_q     <= '0;
            s_wmask_q     <= 4'b0000;
            s_ren_q       <= 1'b0;
            s_wen_q       <= 1'b0;
            m0_wack_q     <= 1'b0;
            m1_wack_q     <= 1'b0;
            m0_rd_valid_q <= 1'b0;
            m1_rd_valid_q <= 1'b0;
            m_rdata_q     <= 32'h0000_0000;
            err_q         <= 1'b0;
            err_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            cnt_q         <= cnt_d;
            s_addr_q      <= s_addr_d;
            s_wdata_q     <= s_wdata_d;
            s_wmask_q     <= s_wmask_d;
            s_ren_q       <= s_ren_d;
            s_wen_q       <= s_wen_d;
            m0_wack_q     <= m0_wack_d;
            m1_wack_q     <= m1_wack_d;
            m0_rd_valid_q <= m0_rd_valid_d;
            m1_rd_valid_q <= m1_rd_valid_d;
            m_rdata_q     <= m_rdata_d;
            err_q         <= err_d;
            err_addr_q    <= err_addr_d;
        end
    end

    assign s_ren       = s_ren_q;
    assign s_wen       = s_wen_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign s_wmask     = s_wmask_q;
    assign m0_wack     = m0_wack_q;
    assign m1_wack     = m1_wack_q;
    assign m0_rd_valid = m0_rd_valid_q;
    assign m1_rd_valid = m1_rd_valid_q;
    assign m_rdata     = m_rdata_q;
    assign err         = err_q;
    assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter with default parameters (W=16, AW=16,
// TIMEOUT=15). Inputs are driven and outputs sampled on the falling clock
// edge; the DUT acts on the rising edge. "Cycle 0" is the cycle in which a
// request is first presented while the arbiter is idle.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_ren, m0_wen, m1_ren, m1_wen;
    logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_rd_valid, m1_rd_valid, m0_wack, m1_wack;
    logic [31:0] m_rdata;
    logic        s_ren, s_wen;
    logic [15:0] s_addr, s_wdata;
    logic [3:0]  s_wmask;
    logic [31:0] s_rdata;
    logic        s_rd_valid;
    logic        err;
    logic [15:0] err_addr;
    logic        err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter #(.W(16), .AW(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m0_rd_valid(m0_rd_valid), .m1_rd_valid(m1_rd_valid),
        .m0_wack(m0_wack), .m1_wack(m1_wack), .m_rdata(m_rdata),
        .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_rdata(s_rdata), .s_rd_valid(s_rd_valid),
        .err(err), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".s_ren"},    64'(s_ren),       64'd0);
        chk({tag, ".s_wen"},    64'(s_wen),       64'd0);
        chk({tag, ".s_addr"},   64'(s_addr),      64'd0);
        chk({tag, ".s_wdata"},  64'(s_wdata),     64'd0);
        chk({tag, ".s_wmask"},  64'(s_wmask),     64'd0);
        chk({tag, ".m0_rdv"},   64'(m0_rd_valid), 64'd0);
        chk({tag, ".m1_rdv"},   64'(m1_rd_valid), 64'd0);
        chk({tag, ".m0_wack"},  64'(m0_wack),     64'd0);
        chk({tag, ".m1_wack"},  64'(m1_wack),     64'd0);
        chk({tag, ".m_rdata"},  64'(m_rdata),     64'd0);
        chk({tag, ".err"},      64'(err),         64'd0);
        chk({tag, ".err_addr"}, 64'(err_addr),    64'd0);
    endtask

    initial begin
        int cnt0;
        int cnt1;
        int k;
        logic exp_owner;

        m0_ren = 1'b0; m0_wen = 1'b0; m1_ren = 1'b0; m1_wen = 1'b0;
        m0_addr = 16'h0000; m1_addr = 16'h0000;
        m0_wdata = 16'h0000; m1_wdata = 16'h0000;
        m0_wmask = 4'b0000; m1_wmask = 4'b0000;
        s_rdata = 32'h0000_0000; s_rd_valid = 1'b0; err_clr = 1'b0;
        rst_n = 1'b1;

        // ---- reset state ----
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- single write: m0, 0x4000 <- 0x00A5, mask 0001 ----
        m0_wen = 1'b1; m0_addr = 16'h4000; m0_wdata = 16'h00A5; m0_wmask = 4'b0001;
        @(negedge clk);                                   // cycle 1
        chk("wr.s_wen",   64'(s_wen),   64'd1);
        chk("wr.s_addr",  64'(s_addr),  64'h4000);
        chk("wr.s_wdata", 64'(s_wdata), 64'h00A5);
        chk("wr.s_wmask", 64'(s_wmask), 64'h1);
        chk("wr.m0_wack", 64'(m0_wack), 64'd1);
        chk("wr.m1_wack", 64'(m1_wack), 64'd0);
        chk("wr.s_ren",   64'(s_ren),   64'd0);
        m0_wen = 1'b0;
        @(negedge clk);                                   // cycle 2
        chk("wr.s_wen_off",  64'(s_wen),   64'd0);
        chk("wr.wack_off",   64'(m0_wack), 64'd0);
        chk("wr.s_ren_off",  64'(s_ren),   64'd0);

        // ---- single read: m1, 0x8010, slave latency 1 ----
        m1_ren = 1'b1; m1_addr = 16'h8010;
        @(negedge clk);                                   // cycle 1
        chk("rd.s_ren",  64'(s_ren),  64'd1);
        chk("rd.s_addr", 64'(s_addr), 64'h8010);
        @(negedge clk);                                   // cycle 2
        chk("rd.s_ren_once", 64'(s_ren),       64'd0);
        chk("rd.addr_hold",  64'(s_addr),      64'h8010);
        chk("rd.early_rdv",  64'(m1_rd_valid), 64'd0);
        s_rd_valid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);                                   // cycle 3
        chk("rd.m1_rdv",  64'(m1_rd_valid), 64'd1);
        chk("rd.m_rdata", 64'(m_rdata),     64'hDEAD_BEEF);
        chk("rd.m0_rdv",  64'(m0_rd_valid), 64'd0);
        s_rd_valid = 1'b0; m1_ren = 1'b0;
        @(negedge clk);                                   // cycle 4
        chk("rd.rdv_off", 64'(m1_rd_valid), 64'd0);

        // ---- round-robin: both masters write continuously after a reset ----
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m0_wen = 1'b1; m0_wdata = 16'h1111; m0_addr = 16'h0100;
        m1_wen = 1'b1; m1_wdata = 16'h2222; m1_addr = 16'h0200;
        cnt0 = 0; cnt1 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i % 2 == 1) begin
                k = (i - 1) / 2;
                exp_owner = (k % 2 == 1);
                chk("rr.m0_wack", 64'(m0_wack), 64'(!exp_owner));
                chk("rr.m1_wack", 64'(m1_wack), 64'(exp_owner));
                chk("rr.s_wdata", 64'(s_wdata), exp_owner ? 64'h2222 : 64'h1111);
                cnt0 += int'(m0_wack);
                cnt1 += int'(m1_wack);
            end
        end
        m0_wen = 1'b0; m1_wen = 1'b0;
        chk("rr.count_m0", 64'(cnt0), 64'd10);
        chk("rr.count_m1", 64'(cnt1), 64'd10);

        // ---- read timeout: m0, 0x6000, slave silent ----
        @(negedge clk);
        m0_ren = 1'b1; m0_addr = 16'h6000;
        @(negedge clk);                                   // cycle 1, first RD
        chk("to.s_ren", 64'(s_ren), 64'd1);
        for (int i = 2; i <= 15; i++) begin
            @(negedge clk);
            chk("to.wait_rdv", 64'(m0_rd_valid), 64'd0);
        end
        chk("to.err_before", 64'(err), 64'd0);
        @(negedge clk);                                   // cycle 16
        chk("to.m0_rdv",   64'(m0_rd_valid), 64'd1);
        chk("to.m_rdata",  64'(m_rdata),     64'd0);
        chk("to.err",      64'(err),         64'd1);
        chk("to.err_addr", 64'(err_addr),    64'h6000);
        m0_ren = 1'b0;
        @(negedge clk);
        m0_ren = 1'b1; m0_addr = 16'h6004;
        repeat (16) @(negedge clk);
        chk("to2.m0_rdv",   64'(m0_rd_valid), 64'd1);
        chk("to2.err",      64'(err),         64'd1);
        chk("to2.err_addr", 64'(err_addr),    64'h6000);
        m0_ren = 1'b0;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr.err",      64'(err),      64'd0);
        chk("clr.err_addr", 64'(err_addr), 64'd0);

        // ---- zero-latency slave: m1, 0x1234 ----
        m1_ren = 1'b1; m1_addr = 16'h1234;
        @(negedge clk);                                   // cycle 1
        chk("l0.s_ren", 64'(s_ren), 64'd1);
        s_rd_valid = 1'b1; s_rdata = 32'hCAFE_F00D;
        @(negedge clk);                                   // cycle 2
        chk("l0.m1_rdv",  64'(m1_rd_valid), 64'd1);
        chk("l0.m_rdata", 64'(m_rdata),     64'hCAFE_F00D);
        s_rd_valid = 1'b0; m1_ren = 1'b0;
        @(negedge clk);

        // ---- stray s_rd_valid while idle ----
        s_rd_valid = 1'b1; s_rdata = 32'h1234_5678;
        @(negedge clk);
        s_rd_valid = 1'b0;
        chk("stray.m0_rdv", 64'(m0_rd_valid), 64'd0);
        chk("stray.m1_rdv", 64'(m1_rd_valid), 64'd0);
        @(negedge clk);
        chk("stray.m0_rdv2", 64'(m0_rd_valid), 64'd0);
        chk("stray.m1_rdv2", 64'(m1_rd_valid), 64'd0);

        // ---- reset mid-read: m0, 0x5000, slave would answer with L=5 ----
        m0_ren = 1'b1; m0_addr = 16'h5000;
        @(negedge clk);                                   // cycle 1
        chk("mid.s_ren", 64'(s_ren), 64'd1);
        @(negedge clk);
        @(negedge clk);                                   // cycle 3, still in RD
        rst_n = 1'b0;
        #1 chk_all_zero("mid");
        m0_ren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s_rd_valid = 1'b1; s_rdata = 32'hBAD0_BAD0;       // late answer
        @(negedge clk);
        s_rd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mid.no_m0_rdv", 64'(m0_rd_valid), 64'd0);
            chk("mid.no_m1_rdv", 64'(m1_rd_valid), 64'd0);
            @(negedge clk);
        end
        m0_wen = 1'b1; m1_wen = 1'b1;
        @(negedge clk);
        chk("mid.tie_m0", 64'(m0_wack), 64'd1);
        chk("mid.tie_m1", 64'(m1_wack), 64'd0);
        m0_wen = 1'b0; m1_wen = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
